// File: rtl/poly_eval_bcd.sv
// poly_eval_bcd: Horner polynomial evaluator with serial double-dabble BCD result.
// Define POLY_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module poly_eval_bcd #(
    parameter int IN_W   = 4,
    parameter int COEF_W = 8,
    parameter int DEG    = 3,
    parameter int OUT_W  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       x,
    input  logic                  coef_we,
    input  logic [3:0]            coef_addr,
    input  logic [COEF_W-1:0]     coef_data,
    output logic                  busy,
    output logic                  done_tick,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int FW = OUT_W + IN_W + COEF_W;
    localparam int CW = (OUT_W > 16) ? $clog2(OUT_W) : 4;
    localparam logic [OUT_W-1:0] MAX = '1;
    localparam logic [3:0] DEG4 = 4'(DEG);

    typedef enum logic [1:0] {IDLE, EVAL, CONV, DONE} state_t;

    state_t                  state_q, state_d;
    logic [OUT_W-1:0]        acc_q, acc_d;
    logic [IN_W-1:0]         x_q, x_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    ovf_out_q, ovf_out_d;
    logic [4*DIGITS-1:0]     dig_q, dig_d, bcd_q, bcd_d, dig_adj;
    logic [(DEG+1)*COEF_W-1:0] coef_q, coef_d;
    logic                    pend_q, pend_d;
    logic [3:0]              pend_addr_q, pend_addr_d;
    logic [COEF_W-1:0]       pend_data_q, pend_data_d;
    logic                    wr_en;
    logic [3:0]              wr_addr;
    logic [COEF_W-1:0]       wr_data;
    logic [FW-1:0]           full;
    logic                    big;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign dig_adj[4*g +: 4] = (dig_q[4*g +: 4] >= 4'd5) ? dig_q[4*g +: 4] + 4'd3 : dig_q[4*g +: 4];
    end

    assign full = FW'(acc_q) * FW'(x_q) + FW'(coef_q[cnt_q*COEF_W +: COEF_W]);
    assign big  = |full[FW-1:OUT_W];

    // A write accepted together with start is parked until DONE so the run sees the old coefficients.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        ovf_out_d   = ovf_out_q;
        dig_d       = dig_q;
        bcd_d       = bcd_q;
        coef_d      = coef_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        wr_en       = 1'b0;
        wr_addr     = coef_addr;
        wr_data     = coef_data;
        case (state_q)
            IDLE: begin
                wr_en = coef_we && coef_addr <= DEG4 && !start;
                if (start) begin
                    x_d         = x;
                    acc_d       = OUT_W'(coef_q[DEG*COEF_W +: COEF_W]);
                    cnt_d       = CW'(DEG == 0 ? OUT_W-1 : DEG-1);
                    ovf_d       = 1'b0;
                    dig_d       = '0;
                    state_d     = (DEG == 0) ? CONV : EVAL;
                    pend_d      = coef_we && coef_addr <= DEG4;
                    pend_addr_d = coef_addr;
                    pend_data_d = coef_data;
                end
            end
            EVAL: begin
                ovf_d = ovf_q | big;
`ifdef POLY_SAT_EN
                acc_d = (ovf_q || big) ? MAX : full[OUT_W-1:0];
`else
                acc_d = full[OUT_W-1:0];
`endif
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = CONV;
                    cnt_d   = CW'(OUT_W-1);
                end
            end
            CONV: begin
                dig_d = {dig_adj[4*DIGITS-2:0], acc_q[OUT_W-1]};
                acc_d = acc_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    bcd_d     = dig_d;
                    ovf_out_d = ovf_q;
                end
            end
            default: begin
                state_d = IDLE;
                wr_en   = pend_q;
                wr_addr = pend_addr_q;
                wr_data = pend_data_q;
                pend_d  = 1'b0;
            end
        endcase
        if (wr_en) coef_d[wr_addr*COEF_W +: COEF_W] = wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            x_q         <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            ovf_out_q   <= 1'b0;
            dig_q       <= '0;
            bcd_q       <= '0;
            coef_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            ovf_out_q   <= ovf_out_d;
            dig_q       <= dig_d;
            bcd_q       <= bcd_d;
            coef_q      <= coef_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign done_tick = state_q == DONE;
    assign ovf       = ovf_out_q;
    assign bcd       = bcd_q;
endmodule

// File: tb/tb_poly_eval_bcd.sv
// tb_poly_eval_bcd: directed checks of poly_eval_bcd in default, 12-bit and degree-0 builds.
module tb_poly_eval_bcd;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_s [3];
    logic [3:0]  x_s     [3];
    logic        we_s    [3];
    logic [3:0]  addr_s  [3];
    logic [7:0]  data_s  [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic        ovf_s   [3];
    logic [27:0] bcd_s   [3];
    logic [15:0] bcd1;
    int          asserts = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    poly_eval_bcd u0 (.clk(clk), .reset_n(reset_n), .start(start_s[0]), .x(x_s[0]), .coef_we(we_s[0]),
        .coef_addr(addr_s[0]), .coef_data(data_s[0]), .busy(busy_s[0]), .done_tick(done_s[0]),
        .ovf(ovf_s[0]), .bcd(bcd_s[0]));
    poly_eval_bcd #(.OUT_W(12), .DIGITS(4)) u1 (.clk(clk), .reset_n(reset_n), .start(start_s[1]),
        .x(x_s[1]), .coef_we(we_s[1]), .coef_addr(addr_s[1]), .coef_data(data_s[1]), .busy(busy_s[1]),
        .done_tick(done_s[1]), .ovf(ovf_s[1]), .bcd(bcd1));
    poly_eval_bcd #(.DEG(0)) u2 (.clk(clk), .reset_n(reset_n), .start(start_s[2]), .x(x_s[2]),
        .coef_we(we_s[2]), .coef_addr(addr_s[2]), .coef_data(data_s[2]), .busy(busy_s[2]),
        .done_tick(done_s[2]), .ovf(ovf_s[2]), .bcd(bcd_s[2]));

    assign bcd_s[1] = {12'h0, bcd1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int id, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        we_s[id] = 1'b1; addr_s[id] = a; data_s[id] = d;
        @(negedge clk);
        we_s[id] = 1'b0;
    endtask

    // poke: 1 = extra start while busy, 2 = c0 write while busy
    task automatic run(input int id, input logic [3:0] xv, input logic we_same, input int poke,
                       input int lat, input logic [31:0] eb, input logic eo);
        int n, extra;
        @(negedge clk);
        start_s[id] = 1'b1; x_s[id] = xv;
        if (we_same) begin we_s[id] = 1'b1; addr_s[id] = 4'd0; data_s[id] = 8'd7; end
        @(negedge clk);
        start_s[id] = 1'b0; we_s[id] = 1'b0; x_s[id] = 4'd0;
        chk("busy_after_start", busy_s[id], 1);
        n = 1;
        while (!done_s[id] && n < 200) begin
            if (n == 5 && poke == 1) start_s[id] = 1'b1;
            if (n == 5 && poke == 2) begin we_s[id] = 1'b1; addr_s[id] = 4'd0; data_s[id] = 8'd5; end
            @(negedge clk);
            start_s[id] = 1'b0; we_s[id] = 1'b0;
            n++;
        end
        chk("done_latency", n, lat);
        chk("bcd", bcd_s[id], eb);
        chk("ovf", ovf_s[id], eo);
        chk("busy_in_done", busy_s[id], 1);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_s[id]) extra++;
        end
        chk("extra_done", extra, 0);
        chk("bcd_hold", bcd_s[id], eb);
        chk("ovf_hold", ovf_s[id], eo);
        chk("idle_after", busy_s[id], 0);
    endtask

    initial begin
        int extra;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0; x_s[i] = 4'd0; we_s[i] = 1'b0; addr_s[i] = 4'd0; data_s[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_s[0], 0);
        chk("rst_done", done_s[0], 0);
        chk("rst_ovf", ovf_s[0], 0);
        chk("rst_bcd", bcd_s[0], 0);
        reset_n = 1'b1;

        wr(0, 3, 1); wr(0, 2, 2); wr(0, 1, 3); wr(0, 0, 4);
        run(0, 2, 0, 0, 24, 28'h0000026, 0);
        run(0, 15, 0, 1, 24, 28'h0003874, 0);

        wr(1, 3, 2); wr(1, 2, 2); wr(1, 1, 3); wr(1, 0, 4);
`ifdef POLY_SAT_EN
        run(1, 15, 0, 0, 16, 28'h4095, 1);
`else
        run(1, 15, 0, 0, 16, 28'h3153, 1);
`endif
        run(1, 1, 0, 0, 16, 28'h0011, 0);

        wr(2, 0, 9);
        wr(2, 1, 8);
        run(2, 7, 0, 2, 21, 28'h9, 0);
        run(2, 3, 0, 0, 21, 28'h9, 0);

        run(0, 2, 1, 0, 24, 28'h0000026, 0);
        run(0, 2, 0, 0, 24, 28'h0000029, 0);

        @(negedge clk);
        start_s[0] = 1'b1; x_s[0] = 4'd2;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_conv_busy", busy_s[0], 1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy_s[0], 0);
        chk("abort_done", done_s[0], 0);
        chk("abort_bcd", bcd_s[0], 0);
        chk("abort_bcd_u2", bcd_s[2], 0);
        @(negedge clk);
        reset_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_s[0]) extra++;
        end
        chk("abort_no_done", extra, 0);
        run(0, 3, 0, 0, 24, 28'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errs);
        $finish;
    end
endmodule
